// File: rtl/scan_signature_analyzer.sv
// ---------------------------------------------------------------------------
// scan_signature_analyzer
//
// Serial-input signature register (SISR) placed after a scan-based circuit
// under test. Each pattern window compresses SHIFT_LEN scan-out bits. After
// NUM_PATTERNS windows the signature is compared against GOLDEN.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   START    in   one-cycle pulse; begins a session from IDLE or DONE
//   SE       in   scan enable shared with the CUT (1 = shift, 0 = capture)
//   SI       in   serial response bit from the CUT scan-out
//   BUSY     out  session in progress (ARMED/SHIFT/WAIT_CAP/COMPARE)
//   DONE     out  session finished; held until START or RST
//   PASS     out  valid while DONE: signature matched and no window error
//   ERR      out  sticky short-window error
//   SIG      out  current signature
//   PAT_CNT  out  number of completed windows
// ---------------------------------------------------------------------------
module scan_signature_analyzer #(
  parameter int unsigned           SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY         = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]  SEED         = 16'h0000,
  parameter int unsigned           SHIFT_LEN    = 60,
  parameter int unsigned           NUM_PATTERNS = 4,
  parameter logic [SIG_WIDTH-1:0]  GOLDEN       = 16'h0000,
  localparam int unsigned          PCW          = $clog2(NUM_PATTERNS + 1),
  localparam int unsigned          BCW          = $clog2(SHIFT_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SE,
  input  logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic                 ERR,
  output logic [SIG_WIDTH-1:0] SIG,
  output logic [PCW-1:0]       PAT_CNT
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_WAIT_CAP = 3'd3;
  localparam logic [2:0] ST_COMPARE  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(SHIFT_LEN - 1);
  localparam logic [PCW-1:0] LAST_PAT = PCW'(NUM_PATTERNS);

  logic [2:0]           state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PCW-1:0]       pat_cnt_q, pat_cnt_d;
  logic                 err_q, err_d;
  logic                 pass_q, pass_d;

  logic                 fb;
  logic [SIG_WIDTH-1:0] sig_step;
  logic [PCW-1:0]       pat_inc;

  // Galois-style SISR step: feedback is the outgoing MSB mixed with the input.
  assign fb       = sig_q[SIG_WIDTH-1] ^ SI;
  assign sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign pat_inc  = pat_cnt_q + PCW'(1);

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    err_d     = err_q;
    pass_d    = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d   = ST_ARMED;
          sig_d     = SEED;
          bit_cnt_d = '0;
          pat_cnt_d = '0;
          err_d     = 1'b0;
          pass_d    = 1'b0;
        end
      end
      // Flush data shifted before the first capture is not part of any window.
      ST_ARMED: begin
        if (!SE) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (SE) begin
          sig_d     = sig_step;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            pat_cnt_d = pat_inc;
            state_d   = (pat_inc == LAST_PAT) ? ST_COMPARE : ST_WAIT_CAP;
          end
        end else begin
          // Capture arrived before the window was full.
          err_d   = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      // Surplus shift cycles between windows are not compressed.
      ST_WAIT_CAP: begin
        if (!SE) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
        pass_d  = (sig_q == GOLDEN) && !err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sig_q     <= SEED;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      err_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  assign BUSY    = (state_q == ST_ARMED) || (state_q == ST_SHIFT) ||
                   (state_q == ST_WAIT_CAP) || (state_q == ST_COMPARE);
  assign DONE    = (state_q == ST_DONE);
  assign PASS    = pass_q;
  assign ERR     = err_q;
  assign SIG     = sig_q;
  assign PAT_CNT = pat_cnt_q;

endmodule

// File: tb/tb_scan_signature_analyzer.sv
// ---------------------------------------------------------------------------
// Bench for scan_signature_analyzer. One instance with default parameters
// runs full sessions through an expected-result queue; a second small
// instance (SHIFT_LEN=4, NUM_PATTERNS=1) checks individual compression steps.
// ---------------------------------------------------------------------------
module tb_scan_signature_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst = 1'b0, start = 1'b0, se = 1'b0, si = 1'b0;
  logic        busy, done, pass, err;
  logic [15:0] sig;
  logic [2:0]  pat_cnt;

  // Step-check instance
  logic        s_rst = 1'b0, s_start = 1'b0, s_se = 1'b0, s_si = 1'b0;
  logic        s_busy, s_done, s_pass, s_err;
  logic [15:0] s_sig;
  logic [0:0]  s_pat_cnt;

  scan_signature_analyzer dut (
    .CLK(clk), .RST(rst), .START(start), .SE(se), .SI(si),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR(err), .SIG(sig), .PAT_CNT(pat_cnt)
  );

  scan_signature_analyzer #(
    .SHIFT_LEN(4), .NUM_PATTERNS(1), .SEED(16'h0000), .GOLDEN(16'h8108)
  ) dut_step (
    .CLK(clk), .RST(s_rst), .START(s_start), .SE(s_se), .SI(s_si),
    .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .ERR(s_err), .SIG(s_sig),
    .PAT_CNT(s_pat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic        err;
    logic [2:0]  pat;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_sig;
  logic        m_err;
  int          m_pat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic se_v, input logic si_v);
    se = se_v;
    si = si_v;
    tick();
  endtask

  // Reference SISR step straight from the algorithm definition.
  function automatic logic [15:0] sisr(input logic [15:0] s, input logic b);
    logic [15:0] nxt;
    nxt = {s[14:0], 1'b0};
    if (s[15] ^ b) nxt = nxt ^ 16'h1021;
    return nxt;
  endfunction

  // Wait for DONE, then pop one expected result and compare.
  task automatic finish_session();
    int n;
    exp_t e;
    check_eq("done_low_in_compare", done, 1'b0);
    check_eq("busy_in_compare", busy, 1'b1);
    n = 0;
    while (!done && n < 8) begin
      drive(1'b0, 1'b0);
      n++;
    end
    check_eq("done_seen", done, 1'b1);
    check_eq("done_latency", n, 1);
    e = sb.pop_front();
    check_eq("sig", sig, e.sig);
    check_eq("pass", pass, e.pass);
    check_eq("err", err, e.err);
    check_eq("pat_cnt", pat_cnt, e.pat);
    check_eq("busy_after_done", busy, 1'b0);
  endtask

  // Full session: 4 windows of 60 bits. Optional short window, single flipped
  // bit, and a START asserted in the middle of SHIFT.
  task automatic run_session(input int short_win, input int short_len,
                             input int flip_win, input int flip_bit, input bit mid_start);
    logic b;
    exp_t e;
    start = 1'b1;
    drive(1'b1, 1'b1);
    start = 1'b0;
    m_sig = 16'h0000;
    m_err = 1'b0;
    m_pat = 0;
    check_eq("busy_rise", busy, 1'b1);
    check_eq("err_cleared", err, 1'b0);
    repeat (3) drive(1'b1, 1'b1);
    check_eq("armed_flush", sig, m_sig);
    for (int w = 0; w < 4; w++) begin
      drive(1'b0, 1'b1);
      check_eq("capture_ignore", sig, m_sig);
      for (int k = 0; k < 60; k++) begin
        if (w == short_win && k == short_len) break;
        b = (w == flip_win && k == flip_bit);
        if (mid_start && w == 1 && k == 10) start = 1'b1;
        drive(1'b1, b);
        start = 1'b0;
        m_sig = sisr(m_sig, b);
      end
      if (w == short_win) begin
        drive(1'b0, 1'b0);
        m_err = 1'b1;
        break;
      end
      m_pat++;
      if (w < 3) check_eq("pat_cnt_window", pat_cnt, m_pat);
      if (w == 0) begin
        repeat (5) drive(1'b1, 1'b1);
        check_eq("waitcap_ignore", sig, m_sig);
      end
    end
    e.sig  = m_sig;
    e.pass = (m_sig == 16'h0000) && !m_err;
    e.err  = m_err;
    e.pat  = 3'(m_pat);
    sb.push_back(e);
    finish_session();
  endtask

  logic [15:0] step_exp [4];
  logic        step_bits [4];

  initial begin
    step_exp  = '{16'h1021, 16'h2042, 16'h4084, 16'h8108};
    step_bits = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Reset with SE toggling
    rst = 1'b1;
    s_rst = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    rst = 1'b0;
    s_rst = 1'b0;
    check_eq("rst_sig", sig, 16'h0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_pass", pass, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_pat_cnt", pat_cnt, 3'd0);

    // Step check on the small instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check_eq("step_busy", s_busy, 1'b1);
    s_se = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      s_se = 1'b1;
      s_si = step_bits[i];
      tick();
      check_eq($sformatf("step_sig%0d", i), s_sig, step_exp[i]);
    end
    s_se = 1'b0;
    s_si = 1'b0;
    check_eq("step_done_early", s_done, 1'b0);
    tick();
    check_eq("step_done", s_done, 1'b1);
    check_eq("step_pass", s_pass, 1'b1);
    check_eq("step_busy_fall", s_busy, 1'b0);
    check_eq("step_pat_cnt", s_pat_cnt, 1'b1);

    // Clean session, one flipped bit, short window, ignored mid-SHIFT START
    run_session(-1, -1, -1, -1, 1'b0);
    run_session(-1, -1, 2, 16, 1'b0);
    check_eq("flip_sig_nonzero", (sig != 16'h0000), 1'b1);
    run_session(1, 30, -1, -1, 1'b0);
    run_session(-1, -1, -1, -1, 1'b1);

    // Reset at bit 40 of window 2, with a simultaneous START
    start = 1'b1;
    drive(1'b1, 1'b0);
    start = 1'b0;
    drive(1'b0, 1'b0);
    for (int k = 0; k < 60; k++) drive(1'b1, k[0]);
    drive(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) drive(1'b1, k[1]);
    check_eq("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    drive(1'b1, 1'b1);
    rst = 1'b0;
    start = 1'b0;
    check_eq("midrst_sig", sig, 16'h0000);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_pat_cnt", pat_cnt, 3'd0);
    drive(1'b0, 1'b1);
    check_eq("midrst_start_overridden", busy, 1'b0);
    run_session(-1, -1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
